// File: rtl/spin_angle_estimator_if.sv
// Sensor-to-panel bundle for spin_angle_estimator: raw IR pin in,
// slice index, validity pulse, lock flag and measured period out.
interface spin_angle_estimator_if #(
  parameter int NUM_SLICES   = 128,
  parameter int PERIOD_WIDTH = 24
);
  localparam int TW = $clog2(NUM_SLICES);

  logic                    ir_tripped;
  logic [TW-1:0]           theta;
  logic                    theta_valid;
  logic                    locked;
  logic [PERIOD_WIDTH-1:0] period_out;

  modport master (
    input  ir_tripped,
    output theta,
    output theta_valid,
    output locked,
    output period_out
  );

  modport slave (
    output ir_tripped,
    input  theta,
    input  theta_valid,
    input  locked,
    input  period_out
  );
endinterface

// File: rtl/spin_angle_estimator.sv
// Turns the once-per-revolution IR beam-break into a slice index
// that advances every period/NUM_SLICES cycles while locked.
module spin_angle_estimator #(
  parameter int NUM_SLICES      = 128,
  parameter int PERIOD_WIDTH    = 24,
  parameter int DEBOUNCE_CYCLES = 1200,
  parameter int MIN_PERIOD      = 2400,
  parameter int MAX_PERIOD      = 12000000
) (
  input logic                    clk_in,
  input logic                    rst_in,
  spin_angle_estimator_if.master bus
);
  localparam int TW  = $clog2(NUM_SLICES);
  localparam int PW  = PERIOD_WIDTH;
  localparam int SLW = PW - TW;
  localparam int LW  = $clog2(DEBOUNCE_CYCLES + 2);

  localparam logic [PW-1:0] MIN_P = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] MAX_P = PW'(MAX_PERIOD);
  localparam logic [LW-1:0] DEB   = LW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] LAST  = TW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    UNLOCKED,
    MEASURE,
    TRACKING
  } state_e;

  state_e state_q, state_d;

  logic          s1_q, s2_q, s3_q, edge_q;
  logic [2:0]    fill_q;
  logic [LW-1:0] lock_q, lock_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] period_q, period_d;
  logic [SLW-1:0] slice_q, slice_d;
  logic [SLW-1:0] sc_q, sc_d;
  logic [TW-1:0] theta_q, theta_d;
  logic          tv_q, tv_d;
  logic          locked_q, locked_d;

  logic acc, long_p, at_max, bound, relock;

  // fill_q marks when s3_q holds a real pin sample, so a pin
  // held high across reset release never looks like a new edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= '0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= bus.ir_tripped;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
      edge_q <= s2_q & ~s3_q & fill_q[2];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= UNLOCKED;
      lock_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      slice_q  <= '0;
      sc_q     <= '0;
      theta_q  <= '0;
      tv_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      slice_q  <= slice_d;
      sc_q     <= sc_d;
      theta_q  <= theta_d;
      tv_q     <= tv_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    slice_d  = slice_q;
    sc_d     = sc_q;
    theta_d  = theta_q;
    tv_d     = 1'b0;

    acc    = edge_q && (lock_q == '0);
    long_p = cnt_q >= MIN_P;
    at_max = cnt_q == MAX_P;
    bound  = sc_q == (slice_q - SLW'(1));
    relock = acc && long_p && (state_q != UNLOCKED);

    if (acc) begin
      lock_d = DEB;
    end else if (lock_q != '0) begin
      lock_d = lock_q - LW'(1);
    end else begin
      lock_d = lock_q;
    end

    cnt_d = at_max ? cnt_q : cnt_q + PW'(1);

    // a good edge wins over a coincident slice boundary or timeout
    if (relock) begin
      state_d  = TRACKING;
      cnt_d    = PW'(1);
      period_d = cnt_q;
      slice_d  = cnt_q[PW-1:TW];
      sc_d     = '0;
      theta_d  = '0;
      tv_d     = 1'b1;
    end else begin
      unique case (state_q)
        UNLOCKED: begin
          if (acc) begin
            state_d = MEASURE;
            cnt_d   = PW'(1);
          end
        end
        MEASURE: begin
          if (at_max) state_d = UNLOCKED;
        end
        TRACKING: begin
          if (at_max) begin
            state_d = UNLOCKED;
            theta_d = '0;
            sc_d    = '0;
          end else if (bound) begin
            sc_d = '0;
            if (theta_q != LAST) begin
              theta_d = theta_q + TW'(1);
              tv_d    = 1'b1;
            end
          end else begin
            sc_d = sc_q + SLW'(1);
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    locked_d = state_d == TRACKING;
  end

  assign bus.theta       = theta_q;
  assign bus.theta_valid = tv_q;
  assign bus.locked      = locked_q;
  assign bus.period_out  = period_q;
endmodule

// File: tb/tb_spin_angle_estimator.sv
// Scoreboard bench for spin_angle_estimator: a revolution-level model
// predicts every theta_valid pulse; a monitor pops and compares them.
module tb_spin_angle_estimator;
  localparam int NS   = 8;
  localparam int PW   = 24;
  localparam int DEB  = 4;
  localparam int MINP = 64;
  localparam int MAXP = 1000;

  typedef struct {
    int t;
    int th;
    int per;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  exp_t e;
  int   rk[$];
  int   rw[$];
  int   nxt;
  int   tc;

  // model: 0 unlocked, 1 measuring, 2 tracking
  int m_mode, m_restart, m_last, m_period;
  int m_slice, m_start, m_lo;

  spin_angle_estimator_if #(
    .NUM_SLICES(NS), .PERIOD_WIDTH(PW)
  ) bus ();

  spin_angle_estimator #(
    .NUM_SLICES(NS), .PERIOD_WIDTH(PW),
    .DEBOUNCE_CYCLES(DEB), .MIN_PERIOD(MINP),
    .MAX_PERIOD(MAXP)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // pulse j of a revolution lands j slices after its edge
  function automatic void emit(int lo, int hi);
    exp_t x;
    for (int j = 0; j < NS; j++) begin
      x.t   = m_start + j * m_slice;
      x.th  = j;
      x.per = m_period;
      if (x.t >= lo && x.t < hi) sb.push_back(x);
    end
  endfunction

  function automatic void timeout_upto(int now);
    int tt;
    tt = m_restart + MAXP;
    if (m_mode != 0 && now >= tt) begin
      if (m_mode == 2) emit(m_lo, tt);
      m_mode = 0;
      m_lo   = tt;
    end
  endfunction

  // d is the cycle at which the edge takes effect
  function automatic void model_edge(int d);
    int p;
    timeout_upto(d - 1);
    if (d - m_last <= DEB) return;
    m_last = d;
    if (m_mode == 0) begin
      m_mode    = 1;
      m_restart = d;
      return;
    end
    p = d - m_restart;
    if (p < MINP) return;
    if (m_mode == 2) emit(m_lo, d);
    m_mode    = 2;
    m_period  = p;
    m_slice   = p / NS;
    m_start   = d;
    m_restart = d;
    m_lo      = d;
  endfunction

  function automatic void model_to(int t);
    timeout_upto(t);
    if (m_mode == 2) begin
      emit(m_lo, t + 1);
      m_lo = t + 1;
    end
  endfunction

  function automatic void model_reset(int t);
    while (sb.size() > 0 && sb[$].t >= t) void'(sb.pop_back());
    m_mode   = 0;
    m_last   = -100000;
    m_period = 0;
    m_lo     = t;
  endfunction

  function automatic int exp_theta(int t);
    int q;
    if (m_mode != 2) return 0;
    q = (t - m_start) / m_slice;
    return (q > NS - 1) ? NS - 1 : q;
  endfunction

  // rise first sampled high at clock k, high for w cycles
  function automatic void push_rise(int k, int w);
    rk.push_back(k);
    rw.push_back(w);
    model_edge(k + 3);
  endfunction

  function automatic void add(int gap, bit glitch);
    nxt += gap;
    if (glitch) begin
      push_rise(nxt, 1);
      push_rise(nxt + 2, 1);
      push_rise(nxt + 4, 8);
    end else begin
      push_rise(nxt, 10);
    end
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive();
    while (rk.size() > 0) begin
      int k;
      int w;
      k = rk.pop_front();
      w = rw.pop_front();
      wait_cyc(k - 1);
      bus.ir_tripped = 1'b1;
      wait_cyc(k - 1 + w);
      bus.ir_tripped = 1'b0;
    end
  endtask

  task automatic check_at(input int t, input string tag);
    model_to(t);
    drive();
    wait_cyc(t);
    chk({tag, "_locked"}, bus.locked, (m_mode == 2) ? 1 : 0);
    chk({tag, "_theta"}, bus.theta, exp_theta(t));
    chk({tag, "_period"}, bus.period_out, m_period);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.theta_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse_cycle", cyc, -1);
      end else begin
        e = sb.pop_front();
        chk("pulse_cycle", cyc, e.t);
        chk("pulse_theta", bus.theta, e.th);
        chk("pulse_period", bus.period_out, e.per);
        chk("pulse_locked", bus.locked, 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ir_tripped = 1'b0;
    m_mode    = 0;
    m_restart = 0;
    m_last    = -100000;
    m_period  = 0;
    m_slice   = 1;
    m_start   = 0;
    m_lo      = 0;

    wait_cyc(3);
    chk("rst_theta", bus.theta, 0);
    chk("rst_valid", bus.theta_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_period", bus.period_out, 0);
    rst = 1'b0;

    nxt = 20;
    add(0, 0);
    repeat (3) add(800, 0);
    check_at(nxt + 53, "lock");

    repeat (2) add(800, 1);
    check_at(nxt + 153, "bounce");

    add(880, 0);
    check_at(nxt + 228, "p880");

    add(800, 0);
    add(600, 0);
    check_at(nxt + 13, "p600");

    add(800, 0);
    add(999, 0);
    check_at(nxt + 13, "p999");

    add(800, 0);
    push_rise(nxt + 40, 5);
    check_at(nxt + 63, "short");

    add(800, 0);
    for (int i = 0; i < 10; i++) begin
      add($urandom_range(650, 990), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0)
        push_rise(nxt + $urandom_range(14, 60), 5);
    end
    check_at(nxt + 203, "rand");

    check_at(m_restart + MAXP - 10, "pre_timeout");
    check_at(m_restart + MAXP + 5, "timeout");

    nxt = cyc + 20;
    add(0, 0);
    check_at(nxt + 8, "measure");
    add(800, 0);
    tc = nxt + 453;
    check_at(tc, "pre_rst");

    rst = 1'b1;
    bus.ir_tripped = 1'b1;
    model_reset(tc);
    #1;
    chk("mid_rst_theta", bus.theta, exp_theta(tc));
    chk("mid_rst_valid", bus.theta_valid, 0);
    chk("mid_rst_locked", bus.locked, 0);
    chk("mid_rst_period", bus.period_out, m_period);
    wait_cyc(tc + 3);
    rst = 1'b0;
    wait_cyc(tc + 25);
    bus.ir_tripped = 1'b0;

    nxt = tc + 40;
    add(0, 0);
    check_at(nxt + 8, "remeasure");
    add(800, 0);
    check_at(nxt + 153, "relock");

    wait_cyc(cyc + 5);
    chk("scoreboard_left", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
